opr_result_arbiter: RTL



---
 rtl/opr_pkg.sv | 19 +
 rtl/rr_arbiter4.sv | 40 ++++
 rtl/opr_result_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/opr_pkg.sv
// Shared definitions for the operand-demux return path: source codes, default
// widths and the result record carried from each unit back to the register file.
package opr_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEST_W_DEF = 4;
   localparam int NSRC       = 4;

   localparam logic [2:0] SRC_WTR   = 3'd0;
   localparam logic [2:0] SRC_INC   = 3'd1;
   localparam logic [2:0] SRC_RESET = 3'd2;
   localparam logic [2:0] SRC_WTA   = 3'd3;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [DEST_W_DEF-1:0] dest;
   } opr_result_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter. The search starts one past the last winner, and
// the winner is remembered only when the consumer takes the grant.
module rr_arbiter4 (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] req_i,
   input  logic       advance_i,
   output logic [3:0] grant_o,
   output logic [1:0] idx_o
);

   logic [1:0] last_grant_q;

   always_comb begin
      logic [1:0] cand;
      logic       found;
      cand    = '0;
      found   = 1'b0;
      grant_o = '0;
      idx_o   = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant_q + 2'(k);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

   // Reset to WTA so that WTR is the first source searched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_grant_q <= 2'd3;
      end else if (advance_i && (|req_i)) begin
         last_grant_q <= idx_o;
      end
   end

endmodule

// File: rtl/opr_result_arbiter.sv
// Buffers one result per WTR/INC/RESET/WTA unit and drains them round-robin onto
// the single register-file write-back port through a registered output stage.
module opr_result_arbiter
   import opr_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEST_W = DEST_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_WTR_valid,
   input  logic [DATA_W-1:0] io_WTR_result,
   input  logic [DEST_W-1:0] io_WTR_dest,
   output logic              io_WTR_ready,
   input  logic              io_INC_valid,
   input  logic [DATA_W-1:0] io_INC_result,
   input  logic [DEST_W-1:0] io_INC_dest,
   output logic              io_INC_ready,
   input  logic              io_RESET_valid,
   input  logic [DATA_W-1:0] io_RESET_result,
   input  logic [DEST_W-1:0] io_RESET_dest,
   output logic              io_RESET_ready,
   input  logic              io_WTA_valid,
   input  logic [DATA_W-1:0] io_WTA_result,
   input  logic [DEST_W-1:0] io_WTA_dest,
   output logic              io_WTA_ready,
   output logic              io_wb_valid,
   output logic [DATA_W-1:0] io_wb_data,
   output logic [DEST_W-1:0] io_wb_dest,
   output logic [2:0]        io_wb_src,
   input  logic              io_wb_ready,
   output logic              io_busy
);

   logic [NSRC-1:0]   valid_in;
   logic [DATA_W-1:0] data_in [NSRC];
   logic [DEST_W-1:0] dest_in [NSRC];

   logic [NSRC-1:0]   full_q, full_d;
   logic [DATA_W-1:0] data_q [NSRC];
   logic [DEST_W-1:0] dest_q [NSRC];

   logic [NSRC-1:0]   accept;
   logic [NSRC-1:0]   grant;
   logic [1:0]        gnt_idx;
   logic              load;

   logic              wb_valid_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [DEST_W-1:0] wb_dest_q;
   logic [2:0]        wb_src_q;

   assign valid_in = {io_WTA_valid, io_RESET_valid, io_INC_valid, io_WTR_valid};

   assign data_in[SRC_WTR[1:0]]   = io_WTR_result;
   assign data_in[SRC_INC[1:0]]   = io_INC_result;
   assign data_in[SRC_RESET[1:0]] = io_RESET_result;
   assign data_in[SRC_WTA[1:0]]   = io_WTA_result;
   assign dest_in[SRC_WTR[1:0]]   = io_WTR_dest;
   assign dest_in[SRC_INC[1:0]]   = io_INC_dest;
   assign dest_in[SRC_RESET[1:0]] = io_RESET_dest;
   assign dest_in[SRC_WTA[1:0]]   = io_WTA_dest;

   // Ready is purely the slot flop, so a slot emptied this edge refills next edge.
   assign accept = valid_in & ~full_q;
   assign load   = (~wb_valid_q | io_wb_ready) & (|full_q);
   assign full_d = (full_q & ~(grant & {NSRC{load}})) | accept;

   rr_arbiter4 u_rr (
      .clock     (clock),
      .reset     (reset),
      .req_i     (full_q),
      .advance_i (load),
      .grant_o   (grant),
      .idx_o     (gnt_idx)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full_q <= '0;
         for (int i = 0; i < NSRC; i++) begin
            data_q[i] <= '0;
            dest_q[i] <= '0;
         end
      end else begin
         full_q <= full_d;
         for (int i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
               data_q[i] <= data_in[i];
               dest_q[i] <= dest_in[i];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_dest_q  <= '0;
         wb_src_q   <= '0;
      end else if (load) begin
         wb_valid_q <= 1'b1;
         wb_data_q  <= data_q[gnt_idx];
         wb_dest_q  <= dest_q[gnt_idx];
         wb_src_q   <= {1'b0, gnt_idx};
      end else if (io_wb_ready) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign io_WTR_ready   = ~full_q[SRC_WTR[1:0]];
   assign io_INC_ready   = ~full_q[SRC_INC[1:0]];
   assign io_RESET_ready = ~full_q[SRC_RESET[1:0]];
   assign io_WTA_ready   = ~full_q[SRC_WTA[1:0]];

   assign io_wb_valid = wb_valid_q;
   assign io_wb_data  = wb_data_q;
   assign io_wb_dest  = wb_dest_q;
   assign io_wb_src   = wb_src_q;
   assign io_busy     = (|full_q) | wb_valid_q;

endmodule
